// File: rtl/seq_src_task_2_if.sv
// Pattern-offer channel for the serial pattern source: pattern word, length,
//   repeat count and abort travel with a valid/ready handshake.
// Ports: master drives the pattern side, slave (the source block) returns pat_ready.
interface seq_src_task_2_if #(
    parameter int PATTERN_W = 24
) ();
    localparam int LEN_W = $clog2(PATTERN_W + 1);

    logic                 pat_valid;
    logic                 pat_ready;
    logic [PATTERN_W-1:0] pat_data;
    logic [LEN_W-1:0]     pat_len;
    logic [7:0]           rep_cnt;
    logic                 abort;

    modport master (
        output pat_valid,
        output pat_data,
        output pat_len,
        output rep_cnt,
        output abort,
        input  pat_ready
    );

    modport slave (
        input  pat_valid,
        input  pat_data,
        input  pat_len,
        input  rep_cnt,
        input  abort,
        output pat_ready
    );
endinterface

// File: rtl/seq_src_task_2.sv
// Serial pattern source: shifts an accepted pattern word out MSB first, with repeat/loop and abort.
// Latency: first bit on 'out' one cycle after acceptance; each bit held BIT_CYCLES cycles.
// Backpressure: pat_ready is high only in IDLE (including the done cycle); abort blocks acceptance.
// Ports: clk, reset (sync, active-high); pat_if (slave: pattern/len/rep/abort in, pat_ready out);
//   out / out_valid / busy / done are registered serial-side outputs.
module seq_src_task_2 #(
    parameter int   PATTERN_W  = 24,
    parameter int   BIT_CYCLES = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    seq_src_task_2_if.slave    pat_if,
    output logic               out,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);
    localparam int LW = $clog2(PATTERN_W + 1);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               state_q,     state_d;
    logic [PATTERN_W-1:0] pat_q,       pat_d;      // original word, reloaded each pass
    logic [PATTERN_W-1:0] sh_q,        sh_d;       // sh_q[MSB] is the bit currently on 'out'
    logic [LW-1:0]        len_q,       len_d;
    logic [LW-1:0]        bit_q,       bit_d;
    logic [CW-1:0]        cyc_q,       cyc_d;
    logic [7:0]           pass_q,      pass_d;     // passes remaining, including current one
    logic                 loop_q,      loop_d;     // rep_cnt was 0: repeat until abort
    logic                 out_q,       out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;

    logic [LW-1:0]        len_eff;
    logic                 accept;
    logic                 bit_end;
    logic                 pass_end;

    // Zero or out-of-range length means "whole word".
    assign len_eff  = ((pat_if.pat_len == '0) || (pat_if.pat_len > LW'(PATTERN_W)))
                      ? LW'(PATTERN_W) : pat_if.pat_len;
    assign accept   = (state_q == S_IDLE) && pat_if.pat_valid && !pat_if.abort;
    assign bit_end  = (cyc_q == CW'(BIT_CYCLES - 1));
    assign pass_end = (bit_q == (len_q - LW'(1)));

    assign pat_if.pat_ready = (state_q == S_IDLE);
    assign out              = out_q;
    assign out_valid        = out_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        sh_d        = sh_q;
        len_d       = len_q;
        bit_d       = bit_q;
        cyc_d       = cyc_q;
        pass_d      = pass_q;
        loop_d      = loop_q;
        out_d       = IDLE_LEVEL;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_SHIFT;
                    pat_d       = pat_if.pat_data;
                    sh_d        = pat_if.pat_data;
                    len_d       = len_eff;
                    bit_d       = '0;
                    cyc_d       = '0;
                    pass_d      = pat_if.rep_cnt;
                    loop_d      = (pat_if.rep_cnt == 8'd0);
                    out_d       = pat_if.pat_data[PATTERN_W-1];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            S_SHIFT: begin
                if (pat_if.abort) begin
                    // Truncate immediately; no done pulse.
                    state_d = S_IDLE;
                    bit_d   = '0;
                    cyc_d   = '0;
                    pass_d  = '0;
                    loop_d  = 1'b0;
                end else begin
                    out_d       = sh_q[PATTERN_W-1];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    if (!bit_end) begin
                        cyc_d = cyc_q + CW'(1);
                    end else begin
                        cyc_d = '0;
                        if (!pass_end) begin
                            bit_d = bit_q + LW'(1);
                            sh_d  = sh_q << 1;
                            out_d = sh_q[PATTERN_W-2];
                        end else if (loop_q || (pass_q > 8'd1)) begin
                            // Seamless wrap: MSB follows the last bit with no gap.
                            bit_d  = '0;
                            sh_d   = pat_q;
                            out_d  = pat_q[PATTERN_W-1];
                            pass_d = loop_q ? pass_q : (pass_q - 8'd1);
                        end else begin
                            state_d     = S_IDLE;
                            bit_d       = '0;
                            pass_d      = '0;
                            out_d       = IDLE_LEVEL;
                            out_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            sh_q        <= '0;
            len_q       <= '0;
            bit_q       <= '0;
            cyc_q       <= '0;
            pass_q      <= '0;
            loop_q      <= 1'b0;
            out_q       <= IDLE_LEVEL;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            sh_q        <= sh_d;
            len_q       <= len_d;
            bit_q       <= bit_d;
            cyc_q       <= cyc_d;
            pass_q      <= pass_d;
            loop_q      <= loop_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule
